whr_nic_inject: RTL and testbench

Network-interface injection stage that sits directly upstream of a wormhole router input port. It accepts a message descriptor (destination, length) and a stream of payload words. It packetizes them into explicit-length-format flits and drives the router's incoming channel. It tracks credit-based flow control returned by the router input buffer and drives the link power-management bit.

---
 rtl/whr_nic_inject_if.sv | 35 +++
 rtl/whr_nic_inject.sv | 184 ++++++++++++++++++
 tb/tb_whr_nic_inject.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/whr_nic_inject_if.sv
// Descriptor and payload handshake bundle for the
// wormhole NIC injection stage.
interface whr_nic_inject_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 2,
  parameter int DATA_WIDTH = 64
);
  logic                  msg_valid;
  logic                  msg_ready;
  logic [ADDR_WIDTH-1:0] msg_dest;
  logic [LEN_WIDTH-1:0]  msg_len;
  logic                  pld_valid;
  logic                  pld_ready;
  logic [DATA_WIDTH-1:0] pld_data;

  modport master (
    output msg_valid,
    output msg_dest,
    output msg_len,
    input  msg_ready,
    output pld_valid,
    output pld_data,
    input  pld_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_dest,
    input  msg_len,
    output msg_ready,
    input  pld_valid,
    input  pld_data,
    output pld_ready
  );
endinterface

// File: rtl/whr_nic_inject.sv
// NIC injection stage: packetizes messages into credit-paced flits.
// Optional stall counter: define WHR_NIC_STALL_CNT_EN.
module whr_nic_inject #(
  parameter int BUFFER_SIZE        = 8,
  parameter int ADDR_WIDTH         = 4,
  parameter int MAX_PAYLOAD_LENGTH = 4,
  parameter int MIN_PAYLOAD_LENGTH = 1,
  parameter int FLIT_DATA_WIDTH    = 64,
  parameter int ENABLE_LINK_PM     = 1,
  localparam int PLW_RAW =
    $clog2(MAX_PAYLOAD_LENGTH - MIN_PAYLOAD_LENGTH + 1),
  localparam int PLW = (PLW_RAW < 1) ? 1 : PLW_RAW,
  localparam int CHW = ENABLE_LINK_PM + 2 + FLIT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  whr_nic_inject_if.slave  io,
  output logic [CHW-1:0]   channel_out,
  input  logic             flow_ctrl_in,
  output logic             error
`ifdef WHR_NIC_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int RW = $clog2(MAX_PAYLOAD_LENGTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_BODY
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CW-1:0]              r_credits;
  logic [CW-1:0]              w_credits_nxt;
  logic [RW-1:0]              r_remaining;
  logic [RW-1:0]              w_remaining_nxt;
  logic [ADDR_WIDTH-1:0]      r_dest;
  logic [PLW-1:0]             r_len;
  logic [CHW-1:0]             r_chan;
  logic                       r_error;
  logic                       w_has_credit;
  logic                       w_launch;
  logic                       w_head;
  logic                       w_overflow;
  logic                       w_link;
  logic                       w_msg_ready;
  logic                       w_pld_ready;
  logic [RW-1:0]              w_total;
  logic [FLIT_DATA_WIDTH-1:0] w_data;
  logic [FLIT_DATA_WIDTH-1:0] w_head_data;
  logic [CHW-1:0]             w_chan;

  assign w_has_credit = (r_credits != '0);
  assign w_total = RW'(r_len) + RW'(MIN_PAYLOAD_LENGTH);
  assign w_link  = (r_state != S_IDLE);

  always_comb begin
    w_head_data = '0;
    w_head_data[ADDR_WIDTH-1:0] = r_dest;
    w_head_data[ADDR_WIDTH +: PLW] = r_len;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_launch        = 1'b0;
    w_head          = 1'b0;
    w_data          = '0;
    w_msg_ready     = 1'b0;
    w_pld_ready     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_msg_ready = 1'b1;
        if (io.msg_valid) begin
          w_state_nxt = S_HEAD;
        end
      end
      S_HEAD: begin
        if (w_has_credit) begin
          w_launch        = 1'b1;
          w_head          = 1'b1;
          w_data          = w_head_data;
          w_remaining_nxt = w_total;
          w_state_nxt     = (w_total != '0) ? S_BODY : S_IDLE;
        end
      end
      S_BODY: begin
        w_pld_ready = w_has_credit;
        if (w_has_credit && io.pld_valid) begin
          w_launch        = 1'b1;
          w_data          = io.pld_data;
          w_remaining_nxt = r_remaining - RW'(1);
          if (r_remaining == RW'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Credit in with no launch at a full count is a router protocol error.
  always_comb begin
    w_credits_nxt = r_credits;
    w_overflow    = 1'b0;
    unique case ({w_launch, flow_ctrl_in})
      2'b10: w_credits_nxt = r_credits - CW'(1);
      2'b01: begin
        if (r_credits == CW'(BUFFER_SIZE)) begin
          w_overflow = 1'b1;
        end else begin
          w_credits_nxt = r_credits + CW'(1);
        end
      end
      default: w_credits_nxt = r_credits;
    endcase
  end

  generate
    if (ENABLE_LINK_PM != 0) begin : g_pm
      assign w_chan = {w_link, w_launch, w_head, w_data};
    end else begin : g_no_pm
      assign w_chan = {w_launch, w_head, w_data};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credits   <= CW'(BUFFER_SIZE);
      r_remaining <= '0;
      r_dest      <= '0;
      r_len       <= '0;
      r_chan      <= '0;
      r_error     <= 1'b0;
    end else begin
      r_credits   <= w_credits_nxt;
      r_remaining <= w_remaining_nxt;
      r_chan      <= w_chan;
      r_error     <= r_error | w_overflow;
      if (r_state == S_IDLE && io.msg_valid) begin
        r_dest <= io.msg_dest;
        r_len  <= io.msg_len;
      end
    end
  end

  assign io.msg_ready = w_msg_ready & reset;
  assign io.pld_ready = w_pld_ready & reset;
  assign channel_out  = r_chan;
  assign error        = r_error;

`ifdef WHR_NIC_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = !w_has_credit &&
                   (r_state == S_HEAD ||
                    (r_state == S_BODY && io.pld_valid));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_whr_nic_inject.sv
// Directed bench for whr_nic_inject: reset, packetizing,
// credit stalls, credit overlap, zero-length and mid-packet reset.
module tb_whr_nic_inject;
  localparam int DW  = 64;
  localparam int CHW = 67;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CHW-1:0] ch;
  logic [CHW-1:0] ch0;
  logic           flow;
  logic           flow0;
  logic           err;
  logic           err0;
  int             errors = 0;
  int             checks = 0;

  always #5 clk = ~clk;

  whr_nic_inject_if #(
    .ADDR_WIDTH(4), .LEN_WIDTH(2), .DATA_WIDTH(DW)
  ) u_if ();
  whr_nic_inject_if #(
    .ADDR_WIDTH(4), .LEN_WIDTH(3), .DATA_WIDTH(DW)
  ) u_if0 ();

`ifdef WHR_NIC_STALL_CNT_EN
  logic [15:0] stall;
  logic [15:0] stall0;
`endif

  whr_nic_inject #(
    .BUFFER_SIZE(8), .ADDR_WIDTH(4),
    .MAX_PAYLOAD_LENGTH(4), .MIN_PAYLOAD_LENGTH(1),
    .FLIT_DATA_WIDTH(DW), .ENABLE_LINK_PM(1)
  ) dut (
    .clk(clk), .reset(rst_n), .io(u_if),
    .channel_out(ch), .flow_ctrl_in(flow), .error(err)
`ifdef WHR_NIC_STALL_CNT_EN
    , .stall_cnt(stall)
`endif
  );

  whr_nic_inject #(
    .BUFFER_SIZE(8), .ADDR_WIDTH(4),
    .MAX_PAYLOAD_LENGTH(4), .MIN_PAYLOAD_LENGTH(0),
    .FLIT_DATA_WIDTH(DW), .ENABLE_LINK_PM(1)
  ) dut0 (
    .clk(clk), .reset(rst_n), .io(u_if0),
    .channel_out(ch0), .flow_ctrl_in(flow0), .error(err0)
`ifdef WHR_NIC_STALL_CNT_EN
    , .stall_cnt(stall0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.msg_valid  = 1'b0;
    u_if.msg_dest   = '0;
    u_if.msg_len    = '0;
    u_if.pld_valid  = 1'b0;
    u_if.pld_data   = '0;
    u_if0.msg_valid = 1'b0;
    u_if0.msg_dest  = '0;
    u_if0.msg_len   = '0;
    u_if0.pld_valid = 1'b0;
    u_if0.pld_data  = '0;
    flow  = 1'b0;
    flow0 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++;
    if (u_if.msg_ready !== 1'b0 || u_if.pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00",
               u_if.msg_ready, u_if.pld_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (ch !== '0) begin
      errors++;
      $display("FAIL reset_chan: got %h want 0", ch);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", err);
    end
    checks++;
    if (u_if.msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_msg_ready: got %b want 1", u_if.msg_ready);
    end
    checks++;
    if (dut.r_credits !== 4'd8) begin
      errors++;
      $display("FAIL reset_credits: got %0d want 8", dut.r_credits);
    end
    flow = 1'b1;
    tick();
    flow = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: got %b want 1", err);
    end
    checks++;
    if (dut.r_credits !== 4'd8) begin
      errors++;
      $display("FAIL overflow_sat: got %0d want 8", dut.r_credits);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0]  dat [3];
    logic [CHW-1:0] exp;
    dat[0] = 64'h1111_2222_3333_4444;
    dat[1] = 64'h5555_6666_7777_8888;
    dat[2] = 64'h9999_AAAA_BBBB_CCCC;
    do_reset();
    u_if.msg_valid = 1'b1;
    u_if.msg_dest  = 4'hA;
    u_if.msg_len   = 2'd2;
    u_if.pld_valid = 1'b1;
    tick();
    u_if.msg_valid = 1'b0;
    checks++;
    if (ch !== '0) begin
      errors++;
      $display("FAIL single_accept: got %h want 0", ch);
    end
    tick();
    exp = {1'b1, 1'b1, 1'b1, 64'h2A};
    checks++;
    if (ch !== exp) begin
      errors++;
      $display("FAIL single_head: got %h want %h", ch, exp);
    end
    checks++;
    if (u_if.pld_ready !== 1'b1 || u_if.msg_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got %b%b want 10",
               u_if.pld_ready, u_if.msg_ready);
    end
    for (int i = 0; i < 3; i++) begin
      u_if.pld_data = dat[i];
      tick();
      exp = {1'b1, 1'b1, 1'b0, dat[i]};
      checks++;
      if (ch !== exp) begin
        errors++;
        $display("FAIL single_body%0d: got %h want %h", i, ch, exp);
      end
    end
    tick();
    checks++;
    if (ch !== '0) begin
      errors++;
      $display("FAIL single_after: got %h want 0", ch);
    end
    checks++;
    if (dut.r_credits !== 4'd4) begin
      errors++;
      $display("FAIL single_credits: got %0d want 4", dut.r_credits);
    end
    u_if.pld_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [13:0]    seen;
    logic [13:0]    exp_v;
    logic [CHW-1:0] exp;
    exp_v = 14'h03DE;
    do_reset();
    u_if.msg_valid = 1'b1;
    u_if.msg_dest  = 4'h5;
    u_if.msg_len   = 2'd2;
    u_if.pld_valid = 1'b1;
    u_if.pld_data  = 64'hBEEF;
    for (int i = 0; i < 14; i++) begin
      tick();
      seen[i] = ch[65];
    end
    checks++;
    if (seen !== exp_v) begin
      errors++;
      $display("FAIL stall_pattern: got %b want %b", seen, exp_v);
    end
    checks++;
    if (dut.r_credits !== 4'd0 || dut.r_state !== ST_HEAD) begin
      errors++;
      $display("FAIL stall_state: got cr=%0d st=%0d want cr=0 st=1",
               dut.r_credits, dut.r_state);
    end
    flow = 1'b1;
    tick();
    flow = 1'b0;
    checks++;
    if (ch[65] !== 1'b0 || dut.r_credits !== 4'd1) begin
      errors++;
      $display("FAIL stall_credit: got v=%b cr=%0d want v=0 cr=1",
               ch[65], dut.r_credits);
    end
    tick();
    exp = {1'b1, 1'b1, 1'b1, 64'h25};
    checks++;
    if (ch !== exp) begin
      errors++;
      $display("FAIL stall_resume: got %h want %h", ch, exp);
    end
  endtask

  task automatic test_overlap();
    logic [11:0] pat;
    pat = 12'hDF7;
    u_if.pld_valid = 1'b0;
    flow = 1'b1;
    tick();
    flow = 1'b0;
    checks++;
    if (dut.r_credits !== 4'd1 || ch[65] !== 1'b0) begin
      errors++;
      $display("FAIL overlap_start: got cr=%0d v=%b want cr=1 v=0",
               dut.r_credits, ch[65]);
    end
    u_if.pld_valid = 1'b1;
    u_if.msg_valid = 1'b1;
    u_if.msg_len   = 2'd3;
    for (int k = 0; k < 12; k++) begin
      flow = pat[k];
      if (k == 4) u_if.msg_len = 2'd0;
      if (k == 10) u_if.msg_valid = 1'b0;
      tick();
      checks++;
      if (ch[65] !== pat[k]) begin
        errors++;
        $display("FAIL overlap_v%0d: got %b want %b", k, ch[65], pat[k]);
      end
    end
    flow = 1'b0;
    u_if.pld_valid = 1'b0;
    checks++;
    if (dut.r_credits !== 4'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL overlap_end: got cr=%0d err=%b want cr=1 err=0",
               dut.r_credits, err);
    end
  endtask

  task automatic test_zero_len();
    logic [CHW-1:0] exp;
    do_reset();
    u_if0.msg_valid = 1'b1;
    u_if0.msg_dest  = 4'h5;
    u_if0.msg_len   = 3'd0;
    u_if0.pld_valid = 1'b1;
    u_if0.pld_data  = 64'hFFFF;
    tick();
    u_if0.msg_valid = 1'b0;
    checks++;
    if (ch0 !== '0 || u_if0.pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_accept: got %h rdy=%b want 0 rdy=0",
               ch0, u_if0.pld_ready);
    end
    tick();
    exp = {1'b1, 1'b1, 1'b1, 64'h5};
    checks++;
    if (ch0 !== exp) begin
      errors++;
      $display("FAIL zero_head: got %h want %h", ch0, exp);
    end
    checks++;
    if (u_if0.pld_ready !== 1'b0 || u_if0.msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_idle: got pr=%b mr=%b want pr=0 mr=1",
               u_if0.pld_ready, u_if0.msg_ready);
    end
    tick();
    checks++;
    if (ch0 !== '0 || u_if0.pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: got %h rdy=%b want 0 rdy=0",
               ch0, u_if0.pld_ready);
    end
    checks++;
    if (dut0.r_credits !== 4'd7 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL zero_credits: got cr=%0d err=%b want cr=7 err=0",
               dut0.r_credits, err0);
    end
    u_if0.pld_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [CHW-1:0] exp;
    do_reset();
    u_if.msg_valid = 1'b1;
    u_if.msg_dest  = 4'h3;
    u_if.msg_len   = 2'd2;
    u_if.pld_valid = 1'b1;
    u_if.pld_data  = 64'hCAFE;
    tick();
    u_if.msg_valid = 1'b0;
    tick();
    tick();
    exp = {1'b1, 1'b1, 1'b0, 64'hCAFE};
    checks++;
    if (ch !== exp) begin
      errors++;
      $display("FAIL mid_body: got %h want %h", ch, exp);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (ch !== '0) begin
      errors++;
      $display("FAIL mid_chan: got %h want 0", ch);
    end
    checks++;
    if (u_if.msg_ready !== 1'b0 || u_if.pld_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready: got %b%b want 00",
               u_if.msg_ready, u_if.pld_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (dut.r_credits !== 4'd8 || dut.r_state !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_state: got cr=%0d st=%0d want cr=8 st=0",
               dut.r_credits, dut.r_state);
    end
    tick();
    tick();
    checks++;
    if (ch !== '0) begin
      errors++;
      $display("FAIL mid_quiet: got %h want 0", ch);
    end
    u_if.pld_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_stall();
    test_overlap();
    test_zero_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
